// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
//   Shared definitions for the PLL lock supervisor: FSM state encoding,
//   default timing parameters, the relock counter width and a small
//   helper for sizing the shared down-counter.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;   // 1 ms at 50 MHz
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRY     = 8;

    localparam int RELOCK_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
//   Two-flop synchroniser for signals crossing into the clk domain.
//   Also used for destination-domain reset synchronisers.
// Ports:
//   clk  in       destination clock
//   rst  in       asynchronous active-high reset, clears both stages
//   d    in  W    asynchronous input
//   q    out W    synchronised output (2 clk edges of latency)
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Drives the PLL reset, waits for lock with a retrying timeout, requires
//   lock to be stable for STABLE_CYCLES before releasing sys_rst, and
//   restarts the PLL whenever lock is lost in RUN.
// Ports:
//   clk         in      50 MHz reference clock (same source as PLL clkin1)
//   rst         in      asynchronous active-high reset
//   pll_lock    in      PLL lock, asynchronous to clk
//   pll_rst     out     PLL RST input, active-high
//   sys_rst     out     downstream reset, active-high (low only in RUN)
//   pll_ready   out     high while in RUN
//   fail        out     high in the terminal FAIL state
//   relock_cnt  out 8   lock losses seen in RUN, saturating at 255
//   state       out 3   current FSM state (debug)
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_lock,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                pll_ready,
    output logic                fail,
    output logic [RELOCK_W-1:0] relock_cnt,
    output logic [2:0]          state
);

    // The counter is loaded with N-1 on entry and the state is left when it
    // reads zero, so it only ever has to hold values below the largest N.
    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    state_t               state_q, state_next;
    logic [CNT_W-1:0]     cnt_q, cnt_next;
    logic [RETRY_W-1:0]   retry_q, retry_next;
    logic [RELOCK_W-1:0]  relock_next;
    logic                 lock_s;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_next  = state_q;
        retry_next  = retry_q;
        relock_next = relock_cnt;

        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q == '0) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same cycle.
                if (lock_s) begin
                    state_next = STABLE;
                end else if (cnt_q == '0) begin
                    retry_next = retry_q + RETRY_W'(1);
                    state_next = (retry_next == RETRY_W'(MAX_RETRY)) ? FAIL : RESET_PLL;
                end
            end
            STABLE: begin
                // Loss takes priority over completion of the stability window.
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                end else if (cnt_q == '0) begin
                    state_next = RUN;
                    retry_next = '0;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_next = RESET_PLL;
                    if (relock_cnt != '1) relock_next = relock_cnt + RELOCK_W'(1);
                end
            end
            FAIL: begin
                state_next = FAIL;
            end
            default: begin
                state_next = RESET_PLL;
            end
        endcase

        if (state_next != state_q) begin
            unique case (state_next)
                RESET_PLL: cnt_next = CNT_W'(RST_CYCLES - 1);
                WAIT_LOCK: cnt_next = CNT_W'(LOCK_TIMEOUT - 1);
                STABLE:    cnt_next = CNT_W'(STABLE_CYCLES - 1);
                default:   cnt_next = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_next = cnt_q - CNT_W'(1);
        end else begin
            cnt_next = cnt_q;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_PLL;
            cnt_q      <= CNT_W'(RST_CYCLES - 1);
            retry_q    <= '0;
            relock_cnt <= '0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            pll_ready  <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state_q    <= state_next;
            cnt_q      <= cnt_next;
            retry_q    <= retry_next;
            relock_cnt <= relock_next;
            // Outputs decode the next state so they move on the same edge.
            pll_rst    <= (state_next == RESET_PLL);
            sys_rst    <= (state_next != RUN);
            pll_ready  <= (state_next == RUN);
            fail       <= (state_next == FAIL);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Directed bench with hand-computed edge counts for RST_CYCLES=4,
//   LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2. Edge n is the n-th
//   rising clk edge after rst is released; checks sample 1 ns after it.
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       pll_rst;
    logic       sys_rst;
    logic       pll_ready;
    logic       fail;
    logic [7:0] relock_cnt;
    logic [2:0] state;

    int tests_run    = 0;
    int tests_failed = 0;

    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_STAB = 3'd2;
    localparam logic [2:0] S_RUN  = 3'd3;
    localparam logic [2:0] S_FAIL = 3'd4;

    pll_lock_supervisor #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_lock   (pll_lock),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .pll_ready  (pll_ready),
        .fail       (fail),
        .relock_cnt (relock_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".state"},      32'(state),      32'(S_RST));
        check({tag, ".pll_rst"},    32'(pll_rst),    1);
        check({tag, ".sys_rst"},    32'(sys_rst),    1);
        check({tag, ".pll_ready"},  32'(pll_ready),  0);
        check({tag, ".fail"},       32'(fail),       0);
        check({tag, ".relock_cnt"}, 32'(relock_cnt), 0);
    endtask

    // Holds rst for two edges, then releases it 1 ns after a rising edge.
    task automatic do_reset(input logic lock_val);
        rst      = 1'b1;
        pll_lock = lock_val;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        pll_lock = 1'b0;
        #1;
        check_reset_outputs("por");

        // ---------------- Normal bring-up ----------------
        do_reset(1'b0);
        step(3);                                        // edge 3
        check("bringup.pll_rst_e3", 32'(pll_rst), 1);
        step(1);                                        // edge 4
        check("bringup.pll_rst_e4", 32'(pll_rst), 0);
        check("bringup.state_e4",   32'(state),   32'(S_WAIT));
        step(6);                                        // edge 10
        pll_lock = 1'b1;
        step(2);                                        // edge 12: lock_s just rose
        check("bringup.state_e12", 32'(state), 32'(S_WAIT));
        step(1);                                        // edge 13: STABLE
        check("bringup.state_e13", 32'(state), 32'(S_STAB));
        step(7);                                        // edge 20
        check("bringup.sys_rst_e20", 32'(sys_rst), 1);
        step(1);                                        // edge 21: 8 after STABLE
        check("bringup.sys_rst_e21",   32'(sys_rst),    0);
        check("bringup.pll_ready_e21", 32'(pll_ready),  1);
        check("bringup.state_e21",     32'(state),      32'(S_RUN));
        check("bringup.relock_e21",    32'(relock_cnt), 0);

        // ---------------- Lock chatter (loss coincides with window end) ----------------
        do_reset(1'b1);
        step(5);                                        // edge 5: STABLE entered
        check("chatter.state_e5", 32'(state), 32'(S_STAB));
        step(5);                                        // edge 10: STABLE cycle 5
        pll_lock = 1'b0;
        step(2);                                        // edge 12
        check("chatter.state_e12",   32'(state),   32'(S_STAB));
        step(1);                                        // edge 13: window would complete, loss wins
        check("chatter.state_e13",   32'(state),   32'(S_WAIT));
        check("chatter.sys_rst_e13", 32'(sys_rst), 1);
        pll_lock = 1'b1;
        step(2);                                        // edge 15
        check("chatter.state_e15", 32'(state), 32'(S_WAIT));
        step(1);                                        // edge 16: STABLE again
        check("chatter.state_e16", 32'(state), 32'(S_STAB));
        step(7);                                        // edge 23
        check("chatter.sys_rst_e23", 32'(sys_rst), 1);
        step(1);                                        // edge 24: full 8-cycle count
        check("chatter.sys_rst_e24", 32'(sys_rst), 0);
        check("chatter.state_e24",   32'(state),   32'(S_RUN));

        // ---------------- Loss in RUN (continues from edge 24) ----------------
        pll_lock = 1'b0;
        step(2);                                        // edge 26
        check("loss.sys_rst_e26", 32'(sys_rst), 0);
        step(1);                                        // edge 27: 3 edges after the fall
        check("loss.sys_rst_e27", 32'(sys_rst),    1);
        check("loss.pll_rst_e27", 32'(pll_rst),    1);
        check("loss.state_e27",   32'(state),      32'(S_RST));
        check("loss.relock_e27",  32'(relock_cnt), 1);
        step(3);                                        // edge 30
        check("loss.pll_rst_e30", 32'(pll_rst), 1);
        step(1);                                        // edge 31
        check("loss.pll_rst_e31", 32'(pll_rst), 0);
        pll_lock = 1'b1;
        step(3);                                        // edge 34: STABLE
        check("loss.state_e34", 32'(state), 32'(S_STAB));
        step(8);                                        // edge 42: released again
        check("loss.sys_rst_e42",   32'(sys_rst),    0);
        check("loss.pll_ready_e42", 32'(pll_ready),  1);
        check("loss.relock_e42",    32'(relock_cnt), 1);

        // ---------------- Saturation (relock_cnt starts at 1) ----------------
        for (int i = 0; i < 260; i++) begin
            pll_lock = 1'b0;
            step(3);                                    // now in RESET_PLL
            pll_lock = 1'b1;
            step(13);                                   // back in RUN
            if (i == 252) check("sat.relock_254", 32'(relock_cnt), 254);
            if (i == 253) check("sat.relock_255", 32'(relock_cnt), 255);
        end
        check("sat.relock_final", 32'(relock_cnt), 255);
        check("sat.state_final",  32'(state),      32'(S_RUN));

        // ---------------- Lock rises on the timeout cycle ----------------
        do_reset(1'b0);
        step(21);                                       // edge 21
        pll_lock = 1'b1;                                // lock_s rises after edge 23
        step(2);                                        // edge 23
        check("race.state_e23", 32'(state), 32'(S_WAIT));
        step(1);                                        // edge 24: timeout cycle, lock wins
        check("race.state_e24",   32'(state),   32'(S_STAB));
        check("race.pll_rst_e24", 32'(pll_rst), 0);

        // ---------------- Timeout and FAIL ----------------
        do_reset(1'b0);
        step(3);                                        // edge 3
        check("to.pll_rst_e3", 32'(pll_rst), 1);
        step(1);                                        // edge 4
        check("to.pll_rst_e4", 32'(pll_rst), 0);
        step(19);                                       // edge 23
        check("to.state_e23", 32'(state), 32'(S_WAIT));
        step(1);                                        // edge 24: first timeout
        check("to.state_e24",   32'(state),   32'(S_RST));
        check("to.pll_rst_e24", 32'(pll_rst), 1);
        step(3);                                        // edge 27
        check("to.pll_rst_e27", 32'(pll_rst), 1);
        step(1);                                        // edge 28
        check("to.pll_rst_e28", 32'(pll_rst), 0);
        step(19);                                       // edge 47
        check("to.state_e47", 32'(state), 32'(S_WAIT));
        check("to.fail_e47",  32'(fail),  0);
        step(1);                                        // edge 48: second timeout
        check("to.state_e48",   32'(state),   32'(S_FAIL));
        check("to.fail_e48",    32'(fail),    1);
        check("to.pll_rst_e48", 32'(pll_rst), 0);
        check("to.sys_rst_e48", 32'(sys_rst), 1);
        pll_lock = 1'b1;
        step(30);
        check("to.state_sticky", 32'(state), 32'(S_FAIL));
        check("to.fail_sticky",  32'(fail),  1);

        // ---------------- Reset during FAIL ----------------
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_in_fail");
        step(1);
        rst = 1'b0;
        step(3);
        check("rst_in_fail.pll_rst_e3", 32'(pll_rst), 1);
        step(1);
        check("rst_in_fail.state_e4", 32'(state), 32'(S_WAIT));

        // ---------------- Reset during STABLE ----------------
        do_reset(1'b1);
        step(7);                                        // edge 7: in STABLE
        check("rst_in_stable.state_e7", 32'(state), 32'(S_STAB));
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_in_stable");
        step(1);
        rst = 1'b0;
        step(4);                                        // edge 4
        check("restart.state_e4",   32'(state),   32'(S_WAIT));
        check("restart.pll_rst_e4", 32'(pll_rst), 0);
        step(1);                                        // edge 5
        check("restart.state_e5", 32'(state), 32'(S_STAB));
        step(8);                                        // edge 13
        check("restart.state_e13",   32'(state),   32'(S_RUN));
        check("restart.sys_rst_e13", 32'(sys_rst), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
